// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int STEPS   = 32;
    localparam int CNT_W   = 6;

    function automatic logic is_div(input md_op_e op);
        return op[1];
    endfunction

    // MULHU and REMU live in the upper accumulator; MUL and DIVU in the shifted word.
    function automatic logic sel_acc(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative 32-step shift-add multiplier / restoring divider borrowing a shared ALU.
// Optional MULDIV_EARLY_OUT_EN: trivial operands (zero factor, zero divisor) finish on accept.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    input  logic [XLEN-1:0] alu_res
);

    md_state_e        state_reg;
    md_op_e           op_reg;
    logic [XLEN-1:0]  acc_reg;      // hi for multiply, remainder for divide
    logic [XLEN-1:0]  word_reg;     // lo for multiply, quotient/dividend for divide
    logic [XLEN-1:0]  opnd_reg;     // multiplicand or divisor
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  rsp_data_reg;

    logic [XLEN:0]    shifted;
    logic             carry;
    logic             take;
    logic [XLEN-1:0]  acc_next;
    logic [XLEN-1:0]  word_next;
    logic [XLEN-1:0]  result_next;

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic early_hit(input md_op_e op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        return is_div(op) ? (b == '0) : ((a == '0) || (b == '0));
    endfunction

    function automatic logic [XLEN-1:0] early_value(input md_op_e op, input logic [XLEN-1:0] a);
        case (op)
            OP_DIVU: return '1;
            OP_REMU: return a;
            default: return '0;
        endcase
    endfunction
`endif

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_data  = rsp_data_reg;

    always_comb begin
        alu_req  = 1'b0;
        alu_ctrl = 4'b0000;
        alu_src1 = '0;
        alu_src2 = '0;
        shifted  = {acc_reg, word_reg[XLEN-1]};
        if (state_reg == ST_RUN) begin
            alu_req = 1'b1;
            if (is_div(op_reg)) begin
                alu_ctrl = ALU_SUB;
                alu_src1 = shifted[XLEN-1:0];
                alu_src2 = opnd_reg;
            end else begin
                alu_ctrl = ALU_ADD;
                alu_src1 = acc_reg;
                alu_src2 = word_reg[0] ? opnd_reg : '0;
            end
        end
    end

    // Carry and the restore decision are derived locally; the ALU only returns a sum/difference.
    always_comb begin
        carry = (alu_res < alu_src1);
        take  = shifted[XLEN] | (shifted[XLEN-1:0] >= opnd_reg);
        if (is_div(op_reg)) begin
            acc_next  = take ? alu_res : shifted[XLEN-1:0];
            word_next = {word_reg[XLEN-2:0], take};
        end else begin
            acc_next  = {carry, alu_res[XLEN-1:1]};
            word_next = {alu_res[0], word_reg[XLEN-1:1]};
        end
        result_next = sel_acc(op_reg) ? acc_next : word_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_MUL;
            acc_reg      <= '0;
            word_reg     <= '0;
            opnd_reg     <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg  <= md_op_e'(req_op);
                        acc_reg <= '0;
                        cnt_reg <= '0;
                        if (is_div(md_op_e'(req_op))) begin
                            word_reg <= req_a;
                            opnd_reg <= req_b;
                        end else begin
                            word_reg <= req_b;
                            opnd_reg <= req_a;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit(md_op_e'(req_op), req_a, req_b)) begin
                            state_reg    <= ST_DONE;
                            rsp_data_reg <= early_value(md_op_e'(req_op), req_a);
                        end else
`endif
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (alu_gnt) begin
                        acc_reg  <= acc_next;
                        word_reg <= word_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(STEPS - 1)) begin
                            state_reg    <= ST_DONE;
                            rsp_data_reg <= result_next;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
